// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run-control monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package run_monitor_pkg;

    // Top FSM uses RUN/DRAIN/RD/DONE. The dump sequencer uses RD/WAIT/OUT and
    // parks in DONE while idle.
    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        RD,
        WAIT,
        OUT,
        DONE
    } state_t;

    localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;
    localparam int          DUMP_INDEX_WIDTH = 16;

endpackage

// File: rtl/run_monitor_if.sv
// Fetch-snoop, DMEM dump-read and dump-stream signals of the run monitor.
// Latency: n/a (wiring only).
// Backpressure: dump stream is valid/ready; the DMEM read port has none (fixed 1-cycle data).
// master = run_monitor side, slave = SoC / consumer side.
interface run_monitor_if;
    import run_monitor_pkg::*;

    logic [31:0]                 inst_from_imem;
    logic                        inst_valid;
    logic                        dmem_rd_en;
    logic [31:0]                 dmem_rd_addr;
    logic [31:0]                 dmem_rd_data;
    logic                        dump_valid;
    logic                        dump_ready;
    logic [31:0]                 dump_data;
    logic [DUMP_INDEX_WIDTH-1:0] dump_index;

    modport master (
        input  inst_from_imem, inst_valid, dmem_rd_data, dump_ready,
        output dmem_rd_en, dmem_rd_addr, dump_valid, dump_data, dump_index
    );

    modport slave (
        output inst_from_imem, inst_valid, dmem_rd_data, dump_ready,
        input  dmem_rd_en, dmem_rd_addr, dump_valid, dump_data, dump_index
    );

endinterface

// File: rtl/run_monitor_dump.sv
// DMEM window dump sequencer: RD -> WAIT -> OUT per word, index counter, optional checksum.
// Latency: read strobe the cycle after start; each word takes >= 3 cycles (RD, WAIT, OUT).
// Backpressure: holds OUT with stable data/index until out_ready; no new read is issued meanwhile.
// Ports: start (1-cycle pulse in), finished (1-cycle pulse out on last accept), rd_* DMEM read
// port, out_* valid/ready stream. Optional checksum port under RUN_MONITOR_CHECKSUM_EN.
module run_monitor_dump
    import run_monitor_pkg::*;
#(
    parameter int          DUMP_WORDS     = 20,
    parameter logic [31:0] DUMP_BASE_ADDR = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        finished,
    output logic                        rd_en,
    output logic [31:0]                 rd_addr,
    input  logic [31:0]                 rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_data,
    output logic [DUMP_INDEX_WIDTH-1:0] out_index
`ifdef RUN_MONITOR_CHECKSUM_EN
    ,
    output logic [31:0]                 checksum
`endif
);

    localparam logic [DUMP_INDEX_WIDTH-1:0] LAST_IDX =
        DUMP_INDEX_WIDTH'((DUMP_WORDS > 0) ? DUMP_WORDS - 1 : 0);

    state_t                      st, st_nxt;
    logic [DUMP_INDEX_WIDTH-1:0] idx;
    logic [31:0]                 data_q;
    logic                        accept;
    logic                        last;

    assign accept    = (st == OUT) && out_ready;
    assign last      = (idx == LAST_IDX);
    assign rd_en     = (st == RD);
    assign rd_addr   = DUMP_BASE_ADDR + {14'd0, idx, 2'b00};
    assign out_valid = (st == OUT);
    assign out_data  = data_q;
    assign out_index = idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= DONE;
            idx    <= '0;
            data_q <= '0;
        end else begin
            st <= st_nxt;
            // DMEM returns data exactly one cycle after the strobe, i.e. in WAIT.
            if (st == WAIT) begin
                data_q <= rd_data;
            end
            if (start) begin
                idx <= '0;
            end else if (accept && !last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        st_nxt   = st;
        finished = 1'b0;
        case (st)
            DONE: if (start) st_nxt = RD;
            RD:   st_nxt = WAIT;
            WAIT: st_nxt = OUT;
            OUT: begin
                if (accept) begin
                    if (last) begin
                        st_nxt   = DONE;
                        finished = 1'b1;
                    end else begin
                        st_nxt = RD;
                    end
                end
            end
            default: st_nxt = DONE;
        endcase
    end

`ifdef RUN_MONITOR_CHECKSUM_EN
    // Rotate-left-by-one then XOR each accepted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= {checksum[30:0], checksum[31]} ^ data_q;
        end
    end
`endif

endmodule

// File: rtl/run_monitor.sv
// Run-control monitor: counts run cycles until ebreak or watchdog, drains, then dumps a DMEM window.
// Latency: dump read DRAIN_CYCLES+1 cycles after halt cycle, 1 cycle after timeout; >= 3 cycles/word.
// Backpressure: dump_valid/dump_data/dump_index held stable until dump_ready; run side has none.
// Ports: clk, reset (async, active high), bus (run_monitor_if.master: fetch snoop, DMEM read,
// dump stream), cycles/running/halted/timed_out/done status. RUN_MONITOR_CHECKSUM_EN adds checksum.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter logic [31:0] HALT_INSN      = EBREAK_INSN,
    parameter int          DRAIN_CYCLES   = 5,
    parameter int          TIMEOUT_CYCLES = 20000,
    parameter int          DUMP_WORDS     = 20,
    parameter logic [31:0] DUMP_BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    run_monitor_if.master        bus,
    output logic [CNT_WIDTH-1:0] cycles,
    output logic                 running,
    output logic                 halted,
    output logic                 timed_out,
    output logic                 done
`ifdef RUN_MONITOR_CHECKSUM_EN
    ,
    output logic [31:0]          checksum
`endif
);

    localparam int     DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // An empty dump window goes straight to DONE instead of starting the sequencer.
    localparam state_t DUMP_ENTRY = (DUMP_WORDS == 0) ? DONE : RD;

    // In this FSM RD stands for the whole dump; the per-word phase lives in the sequencer.
    state_t               st, st_nxt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [CNT_WIDTH-1:0] cyc_inc;
    logic                 halt_hit;
    logic                 timeout_hit;
    logic                 dump_start;
    logic                 dump_finished;

    assign halt_hit    = bus.inst_valid && (bus.inst_from_imem == HALT_INSN);
    assign cyc_inc     = (&cycles) ? cycles : cycles + CNT_WIDTH'(1);
    assign timeout_hit = (cyc_inc == CNT_WIDTH'(TIMEOUT_CYCLES));
    assign running     = (st == RUN);
    assign done        = (st == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= RUN;
            cycles    <= '0;
            halted    <= 1'b0;
            timed_out <= 1'b0;
            drain_cnt <= '0;
        end else begin
            st <= st_nxt;
            if (st == RUN) begin
                cycles <= cyc_inc;
                // Halt has priority over a coincident watchdog expiry.
                if (halt_hit) begin
                    halted <= 1'b1;
                end else if (timeout_hit) begin
                    timed_out <= 1'b1;
                end
            end
            if (st == DRAIN) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            RUN: begin
                if (halt_hit) begin
                    st_nxt = (DRAIN_CYCLES == 0) ? DUMP_ENTRY : DRAIN;
                end else if (timeout_hit) begin
                    st_nxt = DUMP_ENTRY;
                end
            end
            DRAIN: if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) st_nxt = DUMP_ENTRY;
            RD:    if (dump_finished) st_nxt = DONE;
            DONE:  st_nxt = DONE;
            default: st_nxt = DONE;
        endcase
    end

    // Combinational start so the sequencer reaches its RD on the same edge as this FSM.
    assign dump_start = (st_nxt == RD) && (st != RD);

    run_monitor_dump #(
        .DUMP_WORDS     (DUMP_WORDS),
        .DUMP_BASE_ADDR (DUMP_BASE_ADDR)
    ) u_dump (
        .clk       (clk),
        .reset     (reset),
        .start     (dump_start),
        .finished  (dump_finished),
        .rd_en     (bus.dmem_rd_en),
        .rd_addr   (bus.dmem_rd_addr),
        .rd_data   (bus.dmem_rd_data),
        .out_valid (bus.dump_valid),
        .out_ready (bus.dump_ready),
        .out_data  (bus.dump_data),
        .out_index (bus.dump_index)
`ifdef RUN_MONITOR_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

endmodule

// File: tb/tb_run_monitor.sv
// Scoreboard bench for run_monitor: directed runs push expected reads/words/status into queues,
// a negedge monitor pops and compares whenever the DUT strobes, streams or reaches done.
module tb_run_monitor;
    import run_monitor_pkg::*;

    localparam int          DRAIN = 5;
    localparam int          TMO   = 150;
    localparam int          NW    = 4;
    localparam logic [31:0] HALT  = 32'h0010_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    run_monitor_if bus ();
    logic [31:0] cycles;
    logic        running, halted, timed_out, done;
`ifdef RUN_MONITOR_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    run_monitor #(
        .HALT_INSN      (HALT),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TMO),
        .DUMP_WORDS     (NW),
        .DUMP_BASE_ADDR (32'h0000_0000),
        .CNT_WIDTH      (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cycles    (cycles),
        .running   (running),
        .halted    (halted),
        .timed_out (timed_out),
        .done      (done)
`ifdef RUN_MONITOR_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // DMEM model: data one cycle after the strobe.
    logic [31:0] mem [NW];
    always @(posedge clk) begin
        if (bus.dmem_rd_en) bus.dmem_rd_data <= mem[bus.dmem_rd_addr[3:2]];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output %0h with nothing queued", name, act);
    endtask

    typedef struct packed { logic [31:0] data; logic [15:0] idx; } word_t;
    typedef struct packed { logic [31:0] cyc; logic hlt; logic tmo; logic [31:0] chk; } stat_t;

    logic [31:0] exp_addr_q [$];
    word_t       exp_word_q [$];
    stat_t       exp_stat_q [$];

    task automatic push_run(input int cyc, input logic hlt, input logic tmo);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < NW; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_word_q.push_back('{data: mem[i], idx: 16'(i)});
            c = {c[30:0], c[31]} ^ mem[i];
        end
        exp_stat_q.push_back('{cyc: 32'(cyc), hlt: hlt, tmo: tmo, chk: c});
    endtask

    // Monitor
    logic  done_q = 1'b0;
    word_t w;
    stat_t s;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.dmem_rd_en) begin
                if (exp_addr_q.size() == 0) extra("rd_addr", 64'(bus.dmem_rd_addr));
                else check("rd_addr", 64'(bus.dmem_rd_addr), 64'(exp_addr_q.pop_front()));
            end
            if (bus.dump_valid && bus.dump_ready) begin
                if (exp_word_q.size() == 0) begin
                    extra("dump_word", 64'({bus.dump_data, bus.dump_index}));
                end else begin
                    w = exp_word_q.pop_front();
                    check("dump_data", 64'(bus.dump_data), 64'(w.data));
                    check("dump_index", 64'(bus.dump_index), 64'(w.idx));
                end
            end
            if (done && !done_q) begin
                if (exp_stat_q.size() == 0) begin
                    extra("done_status", 64'(cycles));
                end else begin
                    s = exp_stat_q.pop_front();
                    check("cycles", 64'(cycles), 64'(s.cyc));
                    check("halted", 64'(halted), 64'(s.hlt));
                    check("timed_out", 64'(timed_out), 64'(s.tmo));
`ifdef RUN_MONITOR_CHECKSUM_EN
                    check("checksum", 64'(checksum), 64'(s.chk));
`endif
                end
            end
        end
        done_q = done;
    end

    task automatic check_reset(input string name);
        check(name, 64'({cycles, running, halted, timed_out, done,
                         bus.dmem_rd_en, bus.dump_valid, bus.dump_index}),
                    64'({32'd0, 1'b1, 5'b00000, 16'd0}));
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.inst_valid     = 1'b0;
        bus.inst_from_imem = '0;
        bus.dump_ready     = 1'b0;
        exp_addr_q.delete();
        exp_word_q.delete();
        exp_stat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_state");
        reset = 1'b0;
    endtask

    // Cycle k is the k-th clock after reset release; the edge ending it is sampled.
    task automatic run_cycles(input int n, input int halt_at, input int ghost_at);
        for (int k = 1; k <= n; k++) begin
            bus.inst_from_imem = (k == halt_at || k == ghost_at) ? HALT : NOP;
            bus.inst_valid     = (k != ghost_at);
            @(posedge clk);
            #1;
        end
        bus.inst_valid = 1'b0;
    endtask

    task automatic rd_latency(input int exp);
        int n;
        n = 0;
        while (!bus.dmem_rd_en && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rd_latency", 64'(n), 64'(exp));
    endtask

    task automatic wait_done(input logic [31:0] exp_cyc);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_reached", 64'(done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 64'({done, running, bus.dmem_rd_en, bus.dump_valid, cycles}),
                           64'({4'b1000, exp_cyc}));
        check("sb_drained", 64'(exp_addr_q.size() + exp_word_q.size() + exp_stat_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int stall;
        mem[0] = 32'hA5A5_0001;
        mem[1] = 32'h1234_5678;
        mem[2] = 32'hDEAD_BEEF;
        mem[3] = 32'h8000_0003;

        // Halt at cycle 100; halts kept on the bus during drain must be ignored.
        do_reset();
        push_run(100, 1'b1, 1'b0);
        bus.dump_ready = 1'b1;
        run_cycles(100, 100, 0);
        bus.inst_from_imem = HALT;
        bus.inst_valid     = 1'b1;
        rd_latency(DRAIN);
        bus.inst_valid = 1'b0;
        wait_done(32'd100);

        // Halt word with inst_valid=0 at cycle 10 must not match; real halt at 20.
        do_reset();
        push_run(20, 1'b1, 1'b0);
        bus.dump_ready = 1'b1;
        run_cycles(20, 20, 10);
        rd_latency(DRAIN);
        wait_done(32'd20);

        // Watchdog: no halt, dump right after the timeout cycle.
        do_reset();
        push_run(TMO, 1'b0, 1'b1);
        bus.dump_ready = 1'b1;
        run_cycles(TMO, 0, 0);
        rd_latency(0);
        wait_done(32'(TMO));

        // Halt on the watchdog cycle: halt wins.
        do_reset();
        push_run(TMO, 1'b1, 1'b0);
        bus.dump_ready = 1'b1;
        run_cycles(TMO, TMO, 0);
        rd_latency(DRAIN);
        wait_done(32'(TMO));

        // Consumer stalls 7 cycles on word 2.
        do_reset();
        push_run(40, 1'b1, 1'b0);
        run_cycles(40, 40, 0);
        stall = 0;
        n = 0;
        while (!done && n < 300) begin
            if (bus.dump_valid && bus.dump_index == 16'd2 && stall < 7) begin
                bus.dump_ready = 1'b0;
                check("stall_hold", 64'({bus.dump_valid, bus.dmem_rd_en, bus.dump_index, bus.dump_data}),
                                    64'({1'b1, 1'b0, 16'd2, 32'hDEAD_BEEF}));
                stall++;
            end else begin
                bus.dump_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_cycles", 64'(stall), 64'd7);
        wait_done(32'd40);

        // Reset while word 1 is waiting in OUT, then a full rerun from index 0.
        do_reset();
        push_run(30, 1'b1, 1'b0);
        bus.dump_ready = 1'b1;
        run_cycles(30, 30, 0);
        n = 0;
        while (!(bus.dump_valid && bus.dump_index == 16'd1) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.dump_ready = 1'b0;
        check("out_word1_reached", 64'(bus.dump_valid && bus.dump_index == 16'd1), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset("reset_mid_out");
        mem[0] = 32'd1;
        mem[1] = 32'd2;
        mem[2] = 32'd4;
        mem[3] = 32'd8;
        do_reset();
        push_run(25, 1'b1, 1'b0);
        bus.dump_ready = 1'b1;
        run_cycles(25, 25, 0);
        rd_latency(DRAIN);
        wait_done(32'd25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "time limit");
    end

endmodule
